// File: rtl/dino_pkg.sv
// Shared types and widths for the dino runner game controller.
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int ROW_W    = 8;
    localparam int SCORE_W  = 16;
    localparam int PERIOD_W = 24;

endpackage

// File: rtl/dino_game_ctrl_if.sv
// Player/obstacle-side signal bundle of the dino game controller.
interface dino_game_ctrl_if;
    import dino_pkg::*;

    logic               start_btn;
    logic               jump_btn;
    logic [ROW_W-1:0]   obs_row;
    logic               obs_tick;
    logic               obs_clear;
    logic               dino_up;
    logic               game_over;
    logic               running;
    logic [SCORE_W-1:0] score;

    // The controller consumes buttons and the obstacle row, produces the rest.
    modport slave (
        input  start_btn, jump_btn, obs_row,
        output obs_tick, obs_clear, dino_up, game_over, running, score
    );

    modport master (
        output start_btn, jump_btn, obs_row,
        input  obs_tick, obs_clear, dino_up, game_over, running, score
    );

endinterface

// File: rtl/dino_tick_div.sv
// Loadable down-counter producing a one-cycle registered tick every `period` cycles.
module dino_tick_div
    import dino_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                load,
    input  logic                enable,
    output logic                tick
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] count;

    // Count down while enabled; on zero fire the tick and reload period-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (load) begin
                count <= period - ONE;
            end else if (enable) begin
                if (count == '0) begin
                    tick  <= 1'b1;
                    count <= period - ONE;
                end else begin
                    count <= count - ONE;
                end
            end
        end
    end

endmodule

// File: rtl/dino_game_ctrl.sv
// Dino runner sequencer: game FSM, movement tick, jump, collision and score.
module dino_game_ctrl
    import dino_pkg::*;
#(
    parameter logic [PERIOD_W-1:0] TICK_DIV_INIT = 24'd12_000_000,
    parameter logic [PERIOD_W-1:0] TICK_DIV_MIN  = 24'd3_000_000,
    parameter logic [PERIOD_W-1:0] SPEED_STEP    = 24'd500_000,
    parameter logic [SCORE_W-1:0]  SPEED_EVERY   = 16'd32,
    parameter int                  JUMP_TICKS    = 3,
    parameter int                  DINO_BIT      = 6
)(
    input  logic             clk,
    input  logic             reset,
    dino_game_ctrl_if.slave  bus
);

    state_t              state;
    state_t              state_next;
    logic                start_d;
    logic                jump_d;
    logic                armed;
    logic                start_press;
    logic                jump_press;
    logic                go;
    logic                check;
    logic                collide;
    logic                jump_go;
    logic                tick;
    logic                tick_d;
    logic                div_enable;
    logic [PERIOD_W-1:0] div_period;
    logic [PERIOD_W-1:0] period;
    logic [SCORE_W-1:0]  score;
    logic [SCORE_W-1:0]  score_inc;
    logic                speed_up;
    logic [3:0]          jump_cnt;
    logic                dino_up;
    logic                obs_clear;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
    endfunction

    // One extra bit keeps a large step from wrapping the period around.
    function automatic logic [PERIOD_W-1:0] shrink(input logic [PERIOD_W-1:0] p);
        logic [PERIOD_W:0] diff;
        diff = {1'b0, p} - {1'b0, SPEED_STEP};
        if (diff[PERIOD_W] || (diff[PERIOD_W-1:0] < TICK_DIV_MIN))
            return TICK_DIV_MIN;
        return diff[PERIOD_W-1:0];
    endfunction

    // A button already held when reset lifts must not look like a fresh press,
    // so edges are only honoured once one clock has passed after reset.
    assign start_press = armed & bus.start_btn & ~start_d;
    assign jump_press  = armed & bus.jump_btn  & ~jump_d;

    // Button history for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_d <= 1'b0;
            jump_d  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            start_d <= bus.start_btn;
            jump_d  <= bus.jump_btn;
            armed   <= 1'b1;
        end
    end

    // Game state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state plus the per-cycle game decisions (start, collision, jump).
    always_comb begin
        state_next = state;
        go         = 1'b0;
        check      = 1'b0;
        collide    = 1'b0;
        jump_go    = 1'b0;
        case (state)
            IDLE, OVER: begin
                if (start_press) begin
                    state_next = RUN;
                    go         = 1'b1;
                end
            end
            RUN: begin
                // obstacle_gen moved on the tick edge, so the row is judged one cycle later
                check   = tick_d;
                collide = tick_d & bus.obs_row[DINO_BIT] & ~dino_up;
                if (collide) state_next = OVER;
                else         jump_go    = jump_press & ~dino_up;
            end
            default: state_next = IDLE;
        endcase
    end

    // A collision freezes the divider in the same cycle so OVER never sees a tick.
    assign div_enable = (state == RUN) & ~collide;
    assign div_period = go ? TICK_DIV_INIT : period;

    dino_tick_div u_div (
        .clk    (clk),
        .reset  (reset),
        .period (div_period),
        .load   (go),
        .enable (div_enable),
        .tick   (tick)
    );

    assign score_inc = sat_inc(score);
    assign speed_up  = ((score_inc & (SPEED_EVERY - SCORE_W'(1))) == '0) && (score != '1);

    // Score, speed, jump and clear-pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score     <= '0;
            period    <= TICK_DIV_INIT;
            dino_up   <= 1'b0;
            jump_cnt  <= '0;
            obs_clear <= 1'b0;
            tick_d    <= 1'b0;
        end else begin
            obs_clear <= go;
            tick_d    <= tick;
            if (go) begin
                score    <= '0;
                period   <= TICK_DIV_INIT;
                dino_up  <= 1'b0;
                jump_cnt <= '0;
            end else if ((state == RUN) && !collide) begin
                if (check) begin
                    score <= score_inc;
                    if (speed_up) period <= shrink(period);
                end
                if (dino_up) begin
                    if (tick) begin
                        jump_cnt <= jump_cnt - 4'd1;
                        if (jump_cnt == 4'd1) dino_up <= 1'b0;
                    end
                end else if (jump_go) begin
                    dino_up  <= 1'b1;
                    jump_cnt <= 4'(JUMP_TICKS);
                end
            end
        end
    end

    assign bus.obs_tick  = tick;
    assign bus.obs_clear = obs_clear;
    assign bus.dino_up   = dino_up;
    assign bus.game_over = (state == OVER);
    assign bus.running   = (state == RUN);
    assign bus.score     = score;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Bench for dino_game_ctrl: vector table, directed corner sequences and random play
// checked against a tick-schedule model of the game rules.
module tb_dino_game_ctrl;

    localparam int I_INIT  = 4;
    localparam int I_MIN   = 2;
    localparam int I_STEP  = 1;
    localparam int I_EVERY = 4;
    localparam int I_JUMP  = 2;
    localparam int I_BIT   = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dino_game_ctrl_if bus();

    dino_game_ctrl #(
        .TICK_DIV_INIT (24'd4),
        .TICK_DIV_MIN  (24'd2),
        .SPEED_STEP    (24'd1),
        .SPEED_EVERY   (16'd4),
        .JUMP_TICKS    (I_JUMP),
        .DINO_BIT      (I_BIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: game state 0=idle 1=run 2=over; ticks come from an absolute schedule.
    int m_state, m_score, m_period, m_jcnt, m_next_tick;
    bit m_dino, m_clear, m_tick, m_tick_last, m_prev_start, m_prev_jump, m_armed;

    function automatic void model_reset();
        m_state = 0; m_score = 0; m_period = I_INIT; m_jcnt = 0; m_next_tick = 0;
        m_dino = 0; m_clear = 0; m_tick = 0; m_tick_last = 0;
        m_prev_start = 0; m_prev_jump = 0; m_armed = 0;
    endfunction

    function automatic void model_step(input bit st, input bit jp, input logic [7:0] row);
        bit sp, jpp, new_tick, new_clear, hit;
        int n;
        n = cyc;
        sp = m_armed && st && !m_prev_start;
        jpp = m_armed && jp && !m_prev_jump;
        new_tick = 0;
        new_clear = 0;
        if (m_state != 1) begin
            if (sp) begin
                m_state = 1; new_clear = 1; m_score = 0; m_period = I_INIT;
                m_dino = 0; m_jcnt = 0; m_next_tick = n + 1 + I_INIT;
            end
        end else begin
            hit = m_tick_last && row[I_BIT] && !m_dino;
            if (hit) begin
                m_state = 2;
            end else begin
                if (m_next_tick == n + 1) begin
                    new_tick = 1;
                    m_next_tick = n + 1 + m_period;
                end
                if (m_tick_last && m_score < 65535) begin
                    m_score++;
                    if (m_score % I_EVERY == 0)
                        m_period = (m_period - I_STEP < I_MIN) ? I_MIN : m_period - I_STEP;
                end
                if (m_dino) begin
                    if (m_tick) begin
                        m_jcnt--;
                        if (m_jcnt == 0) m_dino = 0;
                    end
                end else if (jpp) begin
                    m_dino = 1;
                    m_jcnt = I_JUMP;
                end
            end
        end
        m_tick_last = m_tick;
        m_tick = new_tick;
        m_clear = new_clear;
        m_prev_start = st;
        m_prev_jump = jp;
        m_armed = 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic compare_model();
        chk("tick",  32'(bus.obs_tick),  32'(m_tick));
        chk("clear", 32'(bus.obs_clear), 32'(m_clear));
        chk("dino",  32'(bus.dino_up),   32'(m_dino));
        chk("over",  32'(bus.game_over), 32'(m_state == 2));
        chk("run",   32'(bus.running),   32'(m_state == 1));
        chk("score", 32'(bus.score),     32'(m_score));
    endtask

    // Drive inputs for one cycle, advance the model on the edge, compare just after it.
    task automatic step(input bit st, input bit jp, input logic [7:0] row);
        bus.start_btn = st;
        bus.jump_btn  = jp;
        bus.obs_row   = row;
        @(posedge clk);
        if (reset) model_reset();
        else       model_step(st, jp, row);
        cyc++;
        #1;
        compare_model();
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        for (int k = 0; k < budget; k++) begin
            step(0, 0, 8'h00);
            n++;
            if (bus.obs_tick) break;
        end
        if (!bus.obs_tick) chk("tick_timeout", 32'(n), 32'hFFFF_FFFF);
    endtask

    typedef struct {
        bit         st;
        bit         jp;
        logic [7:0] row;
        bit         tick;
        bit         clear;
        bit         run;
        bit         over;
        int         score;
    } vec_t;

    vec_t vt[18];
    int   gaps[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        //        st jp row    tick clr run ovr score
        vt[0]  = '{1, 0, 8'h00, 0, 1, 1, 0, 0};
        vt[1]  = '{0, 0, 8'h00, 0, 0, 1, 0, 0};
        vt[2]  = '{0, 0, 8'h00, 0, 0, 1, 0, 0};
        vt[3]  = '{0, 0, 8'h00, 0, 0, 1, 0, 0};
        vt[4]  = '{0, 0, 8'h00, 1, 0, 1, 0, 0};
        vt[5]  = '{0, 0, 8'h00, 0, 0, 1, 0, 0};
        vt[6]  = '{0, 0, 8'h00, 0, 0, 1, 0, 1};
        vt[7]  = '{0, 0, 8'h00, 0, 0, 1, 0, 1};
        vt[8]  = '{0, 0, 8'h00, 1, 0, 1, 0, 1};
        vt[9]  = '{0, 0, 8'h00, 0, 0, 1, 0, 1};
        vt[10] = '{0, 0, 8'h00, 0, 0, 1, 0, 2};
        vt[11] = '{0, 0, 8'h00, 0, 0, 1, 0, 2};
        vt[12] = '{0, 0, 8'h00, 1, 0, 1, 0, 2};
        vt[13] = '{0, 0, 8'h00, 0, 0, 1, 0, 2};
        vt[14] = '{0, 0, 8'h40, 0, 0, 0, 1, 2};
        vt[15] = '{0, 0, 8'h00, 0, 0, 0, 1, 2};
        vt[16] = '{0, 0, 8'h00, 0, 0, 0, 1, 2};
        vt[17] = '{0, 0, 8'h00, 0, 0, 0, 1, 2};

        gaps = '{4, 4, 4, 4, 4, 3, 3, 3, 3, 2, 2, 2, 2, 2, 2};

        // Reset state
        reset = 1'b1;
        bus.start_btn = 1'b0;
        bus.jump_btn  = 1'b0;
        bus.obs_row   = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_model();
        chk("rst_score", 32'(bus.score), 32'd0);
        #2 reset = 1'b0;
        step(0, 0, 8'h00);

        // Start, first ticks, scoring and a plain collision from the vector table
        for (int i = 0; i < 18; i++) begin
            step(vt[i].st, vt[i].jp, vt[i].row);
            chk($sformatf("vec%0d_tick", i),  32'(bus.obs_tick),  32'(vt[i].tick));
            chk($sformatf("vec%0d_clear", i), 32'(bus.obs_clear), 32'(vt[i].clear));
            chk($sformatf("vec%0d_run", i),   32'(bus.running),   32'(vt[i].run));
            chk($sformatf("vec%0d_over", i),  32'(bus.game_over), 32'(vt[i].over));
            chk($sformatf("vec%0d_score", i), 32'(bus.score),     32'(vt[i].score));
        end

        // Jump save, press while airborne ignored, dino lands after two ticks
        step(1, 0, 8'h00);
        chk("restart_clear", 32'(bus.obs_clear), 32'd1);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        step(0, 1, 8'h00);
        chk("jump_up", 32'(bus.dino_up), 32'd1);
        step(0, 0, 8'h00);
        chk("jump_tick1", 32'(bus.obs_tick), 32'd1);
        step(0, 0, 8'h40);
        step(0, 0, 8'h40);
        chk("jump_saved_over", 32'(bus.game_over), 32'd0);
        chk("jump_saved_score", 32'(bus.score), 32'd1);
        step(0, 1, 8'h40);
        step(0, 0, 8'h00);
        chk("jump_tick2", 32'(bus.obs_tick), 32'd1);
        step(0, 0, 8'h00);
        chk("dino_fall", 32'(bus.dino_up), 32'd0);
        step(0, 0, 8'h00);
        chk("score_after_land", 32'(bus.score), 32'd2);

        // Jump press in the same cycle as the collision check does not help
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        chk("pre_hit_tick", 32'(bus.obs_tick), 32'd1);
        step(0, 0, 8'h00);
        step(0, 1, 8'h40);
        chk("late_jump_over", 32'(bus.game_over), 32'd1);
        chk("late_jump_dino", 32'(bus.dino_up), 32'd0);
        chk("late_jump_score", 32'(bus.score), 32'd2);

        // Restart from OVER, then speed ramp down to the floor
        step(0, 0, 8'h00);
        step(1, 0, 8'h00);
        chk("over_restart_clear", 32'(bus.obs_clear), 32'd1);
        chk("over_restart_score", 32'(bus.score), 32'd0);
        chk("over_restart_run", 32'(bus.running), 32'd1);
        for (int g = 0; g < 15; g++) begin
            wait_tick(20, n);
            chk($sformatf("ramp_gap%0d", g), 32'(n), 32'(gaps[g]));
        end

        // Collide at the fast period, restart, period must be back to the initial value
        step(0, 0, 8'h00);
        step(0, 0, 8'h40);
        chk("ramp_hit_over", 32'(bus.game_over), 32'd1);
        step(0, 0, 8'h00);
        chk("no_tick_in_over", 32'(bus.obs_tick), 32'd0);
        step(1, 0, 8'h00);
        wait_tick(20, n);
        chk("restore_gap1", 32'(n), 32'd4);
        wait_tick(20, n);
        chk("restore_gap2", 32'(n), 32'd4);

        // Asynchronous reset between edges, start held through release
        step(0, 0, 8'h00);
        bus.start_btn = 1'b1;
        #3 reset = 1'b1;
        model_reset();
        #1;
        chk("async_run",   32'(bus.running),   32'd0);
        chk("async_over",  32'(bus.game_over), 32'd0);
        chk("async_score", 32'(bus.score),     32'd0);
        chk("async_tick",  32'(bus.obs_tick),  32'd0);
        chk("async_clear", 32'(bus.obs_clear), 32'd0);
        chk("async_dino",  32'(bus.dino_up),   32'd0);
        step(1, 0, 8'h00);
        step(1, 0, 8'h00);
        #2 reset = 1'b0;
        step(1, 0, 8'h00);
        step(1, 0, 8'h00);
        step(1, 0, 8'h00);
        chk("held_start_idle", 32'(bus.running), 32'd0);
        step(0, 0, 8'h00);
        step(1, 0, 8'h00);
        chk("fresh_start_run", 32'(bus.running), 32'd1);

        // Random play against the model
        for (int r = 0; r < 3000; r++) begin
            logic [7:0] row;
            row = 8'($urandom);
            row[I_BIT] = ($urandom_range(0, 2) == 0);
            step($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0, row);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dino_game_ctrl.md
Name: dino_game_ctrl

Overview:
Top-level sequencer for the dino runner datapath. It generates the slow `obs_tick` movement strobe that drives `obstacle_gen`, and it clears the obstacle field when a game starts. It tracks the dino's jump and detects collisions against the obstacle row `down`, feeding it back as `obs_row`. It runs the IDLE/RUN/OVER game state machine, keeps the score, and shortens the tick period as the score rises.

Parameters:
TICK_DIV_INIT, 24'd12_000_000, initial tick period in clk cycles (>=2)
TICK_DIV_MIN, 24'd3_000_000, floor for the tick period (>=2, <=TICK_DIV_INIT)
SPEED_STEP, 24'd500_000, amount the period shrinks at each speed-up
SPEED_EVERY, 16'd32, score interval between speed-ups (power of two)
JUMP_TICKS, 3, number of ticks the dino stays airborne (1..15)
DINO_BIT, 6, bit of obs_row occupied by the dino

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start_btn  in  1  synchronized start level; rising edge detected internally
jump_btn  in  1  synchronized jump level; rising edge detected internally
obs_row  in  8  obstacle row from obstacle_gen `down`
obs_tick  out  1  one-cycle movement strobe to obstacle_gen `tick`
obs_clear  out  1  one-cycle registered clear pulse to obstacle_gen reset
dino_up  out  1  dino airborne
game_over  out  1  high in OVER
running  out  1  high in RUN
score  out  16  ticks survived, saturating

Behaviour:
- Reset values:
  - state=IDLE; all outputs 0; score=0.
  - Period register = TICK_DIV_INIT; divider count=0; jump counter=0.
  - Button edge registers = 0.
- Edge detection: a press is `btn & ~btn_d`, where `btn_d` is a 1-cycle delayed copy. Holding a button does not repeat.
- IDLE:
  - start press -> RUN.
  - In the same cycle, register obs_clear=1 (visible next cycle), score=0, period=TICK_DIV_INIT, divider=TICK_DIV_INIT-1, dino_up=0.
- RUN: the divider decrements every cycle.
  - At 0: obs_tick=1 for exactly one cycle and the divider reloads period-1.
  - First tick occurs TICK_DIV_INIT cycles after the obs_clear cycle.
  - obs_tick and obs_clear are never high together.
- Collision check: performed in the cycle after obs_tick (obstacle_gen updates `down` on the tick edge).
  - If obs_row[DINO_BIT]=1 and registered dino_up=0 -> OVER next cycle; score is not incremented.
  - Otherwise score += 1, saturating at 16'hFFFF.
- Speed-up: when the incremented score is a multiple of SPEED_EVERY, period = max(period-SPEED_STEP, TICK_DIV_MIN). Compute the subtraction 25 bits wide to avoid underflow. The new period applies at the next reload.
- Jump:
  - A jump press in RUN with dino_up=0 sets dino_up=1 and jump counter=JUMP_TICKS.
  - Each obs_tick decrements the counter; when it reaches 0, dino_up=0 in the same update.
  - A press while airborne is ignored.
  - A press in the same cycle as a collision check does not save the dino: the check uses pre-press dino_up.
- OVER:
  - Divider frozen; no obs_tick; score, period and dino_up held; game_over=1.
  - start press -> RUN with the same actions as IDLE->RUN.
- Start press in RUN: ignored. Jump press in IDLE/OVER: ignored.
- Reset mid-game: immediate return to reset values.
- Note: obs_clear is registered (glitch-free). Integration ORs it with the system reset into obstacle_gen's reset.

Decomposition:
- Shared package `dino_pkg`: state encoding (IDLE=2'd0, RUN=2'd1, OVER=2'd2), row width 8, score width 16, period width 24.
- One natural sub-module: `dino_tick_div`, a loadable down-counter with a period input, load/enable inputs and a tick output. The FSM, jump, collision and score logic stay in `dino_game_ctrl`.

Test Plan:
All scenarios use TICK_DIV_INIT=4, TICK_DIV_MIN=2, SPEED_STEP=1, SPEED_EVERY=4, JUMP_TICKS=2, DINO_BIT=6.
1. Reset, then start pulse: obs_clear high 1 cycle; obs_tick every 4 cycles starting 4 cycles later; running=1; score increments 1 per tick with obs_row=0.
2. Speed ramp, obs_row=0: after score reaches 4 the tick spacing is 3 cycles; after 8 it is 2; after 12 it stays 2 (floor).
3. Collision: drive obs_row=8'b0100_0000 the cycle after a tick, dino_up=0 -> game_over=1 next cycle, score frozen, no further obs_tick.
4. Jump save: jump press before the tick, obs_row bit6=1 at the check -> no OVER, score increments; dino_up falls after the 2nd tick; a second press while airborne leaves the counter unchanged.
5. Simultaneous jump press and collision check -> OVER; start press in OVER -> obs_clear pulse, score=0, period back to 4.
6. Async reset asserted mid-RUN between clock edges -> all outputs 0 immediately; start held high through reset release produces no start (no edge).
